// File: rtl/cpu_defines.sv
// cpu_defines: shared widths, encodings and constants for the siiCpu pipeline
package cpu_defines;
    localparam int XLEN = 32;
    localparam int SPM_ADDR_W = 12;
    localparam logic READ = 1'b1;
    localparam logic WRITE = 1'b0;
    localparam logic [XLEN-1:0] NOP_INSN = 32'h0000_0013;
    typedef logic [XLEN-1:0] word_t;
endpackage

// File: rtl/if_stage_if_id_reg.sv
// if_id_reg: IF/ID pipeline register
//   clk, rst_ (async active-low)  stall: hold all outputs  flush: insert a NOP bubble (pc holds)
//   in_pc/in_insn/in_en: next values   pc/insn/en: registered IF/ID outputs
module if_id_reg import cpu_defines::*; #(
    parameter word_t NOP = cpu_defines::NOP_INSN
) (
    input  logic  clk,
    input  logic  rst_,
    input  logic  stall,
    input  logic  flush,
    input  word_t in_pc,
    input  word_t in_insn,
    input  logic  in_en,
    output word_t pc,
    output word_t insn,
    output logic  en
);
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            pc   <= '0;
            insn <= NOP;
            en   <= 1'b0;
        end else if (flush) begin
            insn <= NOP;
            en   <= 1'b0;
        end else if (!stall) begin
            pc   <= in_pc;
            insn <= in_insn;
            en   <= in_en;
        end
    end
endmodule

// File: rtl/if_stage.sv
// if_stage: instruction fetch; issues one spm read per cycle and pairs each returned word with its PC
//   clk, rst_ (async active-low)  stall: hold PC and IF/ID  flush/new_pc: squash and redirect
//   if_spm_*: spm instruction port (read-only, strobe active low)
//   if_pc/if_insn/if_en: IF/ID register outputs
module if_stage import cpu_defines::*; #(
    parameter word_t RESET_VECTOR = 32'h0000_0000,
    parameter int    SPM_ADDR_W   = cpu_defines::SPM_ADDR_W,
    parameter word_t NOP_INSN     = cpu_defines::NOP_INSN
) (
    input  logic                  clk,
    input  logic                  rst_,
    input  logic                  stall,
    input  logic                  flush,
    input  word_t                 new_pc,
    output logic [SPM_ADDR_W-1:0] if_spm_addr,
    output logic                  if_spm_as_,
    output logic                  if_spm_rw,
    output word_t                 if_spm_wr_data,
    input  word_t                 if_spm_rd_data,
    output word_t                 if_pc,
    output word_t                 if_insn,
    output logic                  if_en
);
    localparam logic [0:0] RUN  = 1'b0;
    localparam logic [0:0] HOLD = 1'b1;

    word_t      pc;
    word_t      rsp_pc;
    logic       rsp_vld;
    word_t      hold_insn;
    logic [0:0] state;
    word_t      cur_insn;

    assign if_spm_addr    = pc[SPM_ADDR_W+1:2];
    assign if_spm_as_     = ~rst_;
    assign if_spm_rw      = READ;
    assign if_spm_wr_data = '0;

    // While stalled the spm keeps re-reading pc, so the word for rsp_pc is only
    // valid on the first stalled cycle; it is parked in hold_insn until release.
    assign cur_insn = (state == HOLD) ? hold_insn : if_spm_rd_data;

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            pc        <= RESET_VECTOR;
            rsp_pc    <= '0;
            rsp_vld   <= 1'b0;
            hold_insn <= '0;
            state     <= RUN;
        end else if (flush) begin
            pc      <= new_pc & ~word_t'(3);
            rsp_vld <= 1'b0;
            state   <= RUN;
        end else if (stall) begin
            if (state == RUN) begin
                hold_insn <= if_spm_rd_data;
                state     <= HOLD;
            end
        end else begin
            rsp_pc  <= pc;
            rsp_vld <= 1'b1;
            pc      <= pc + 32'd4;
            state   <= RUN;
        end
    end

    if_id_reg #(.NOP(NOP_INSN)) u_if_id_reg (
        .clk     (clk),
        .rst_    (rst_),
        .stall   (stall),
        .flush   (flush),
        .in_pc   (rsp_pc),
        .in_insn (rsp_vld ? cur_insn : NOP_INSN),
        .in_en   (rsp_vld),
        .pc      (if_pc),
        .insn    (if_insn),
        .en      (if_en)
    );
endmodule

// File: tb/tb_if_stage.sv
// tb_if_stage: self-checking bench for if_stage with a behavioural spm on the IF port
module tb_if_stage;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst_ = 1'b0;
    logic        stall = 1'b0;
    logic        flush = 1'b0;
    logic [31:0] new_pc = '0;
    logic [11:0] if_spm_addr;
    logic        if_spm_as_;
    logic        if_spm_rw;
    logic [31:0] if_spm_wr_data;
    logic [31:0] if_spm_rd_data = '0;
    logic [31:0] if_pc;
    logic [31:0] if_insn;
    logic        if_en;

    int checks = 0;
    int errors = 0;

    logic [31:0] mem [4096];

    // PC-level reference: next fetch address, PC in flight, and expected outputs
    logic [31:0] m_pc, m_rsp, m_if_pc, m_insn;
    logic        m_vld, m_en;

    if_stage dut (
        .clk            (clk),
        .rst_           (rst_),
        .stall          (stall),
        .flush          (flush),
        .new_pc         (new_pc),
        .if_spm_addr    (if_spm_addr),
        .if_spm_as_     (if_spm_as_),
        .if_spm_rw      (if_spm_rw),
        .if_spm_wr_data (if_spm_wr_data),
        .if_spm_rd_data (if_spm_rd_data),
        .if_pc          (if_pc),
        .if_insn        (if_insn),
        .if_en          (if_en)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (!if_spm_as_) if_spm_rd_data <= mem[if_spm_addr];

    always @(negedge clk) begin
        if (rst_) begin
            checks++;
            if (if_spm_rw !== 1'b1 || if_spm_wr_data !== 32'h0 || if_spm_as_ !== 1'b0 || if_spm_addr !== m_pc[13:2]) begin
                errors++;
                $display("FAIL iface: rw=%b wr_data=%h as_=%b addr=%h, required rw=1 wr_data=0 as_=0 addr=%h",
                         if_spm_rw, if_spm_wr_data, if_spm_as_, if_spm_addr, m_pc[13:2]);
            end
        end
    end

    function automatic logic [31:0] insn_of(input logic [31:0] pc);
        return 32'h1000_0000 + {20'h0, pc[13:2]};
    endfunction

    task automatic model_reset();
        m_pc = 32'h0; m_rsp = 32'h0; m_vld = 1'b0;
        m_if_pc = 32'h0; m_insn = NOP; m_en = 1'b0;
    endtask

    task automatic step(input logic s, input logic f, input logic [31:0] np);
        stall = s; flush = f; new_pc = np;
        @(posedge clk);
        if (f) begin
            m_pc = {np[31:2], 2'b00}; m_vld = 1'b0; m_en = 1'b0; m_insn = NOP;
        end else if (!s) begin
            m_if_pc = m_rsp;
            m_insn = m_vld ? insn_of(m_rsp) : NOP;
            m_en = m_vld;
            m_rsp = m_pc; m_vld = 1'b1; m_pc = m_pc + 32'd4;
        end
        #1;
    endtask

    task automatic test_reset();
        #12;
        checks++;
        if (if_en !== 1'b0 || if_insn !== NOP || if_pc !== 32'h0 || if_spm_as_ !== 1'b1) begin
            errors++;
            $display("FAIL reset: en=%b insn=%h pc=%h as_=%b, required 0 %h 0 1", if_en, if_insn, if_pc, if_spm_as_, NOP);
        end
        @(negedge clk); #1 rst_ = 1'b1;
        model_reset();
    endtask

    task automatic test_sequence();
        step(0, 0, 0);
        checks++;
        if (if_en !== 1'b0) begin
            errors++;
            $display("FAIL first_latency: en=%b after one posedge, required 0", if_en);
        end
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 0);
            checks++;
            if (if_en !== 1'b1 || if_pc !== 32'(4 * i) || if_insn !== 32'h1000_0000 + 32'(i)) begin
                errors++;
                $display("FAIL sequence[%0d]: en=%b pc=%h insn=%h, required 1 %h %h", i, if_en, if_pc, if_insn, 4 * i, 32'h1000_0000 + 32'(i));
            end
        end
    endtask

    task automatic test_stall();
        for (int i = 0; i < 3; i++) begin
            step(1, 0, 0);
            checks++;
            if (if_en !== 1'b1 || if_pc !== 32'h8 || if_insn !== 32'h1000_0002) begin
                errors++;
                $display("FAIL stall_hold[%0d]: en=%b pc=%h insn=%h, required 1 8 10000002", i, if_en, if_pc, if_insn);
            end
        end
        for (int i = 0; i < 2; i++) begin
            step(0, 0, 0);
            checks++;
            if (if_en !== 1'b1 || if_pc !== 32'(12 + 4 * i) || if_insn !== 32'h1000_0003 + 32'(i)) begin
                errors++;
                $display("FAIL stall_release[%0d]: en=%b pc=%h insn=%h, required 1 %h %h", i, if_en, if_pc, if_insn, 12 + 4 * i, 32'h1000_0003 + 32'(i));
            end
        end
    endtask

    task automatic test_flush();
        step(0, 1, 32'h40);
        checks++;
        if (if_en !== 1'b0 || if_insn !== NOP) begin
            errors++;
            $display("FAIL flush_bubble: en=%b insn=%h, required 0 %h", if_en, if_insn, NOP);
        end
        step(0, 0, 0);
        checks++;
        if (if_en !== 1'b0) begin
            errors++;
            $display("FAIL flush_refill: en=%b, required 0", if_en);
        end
        step(0, 0, 0);
        checks++;
        if (if_en !== 1'b1 || if_pc !== 32'h40 || if_insn !== 32'h1000_0010) begin
            errors++;
            $display("FAIL flush_target: en=%b pc=%h insn=%h, required 1 40 10000010", if_en, if_pc, if_insn);
        end
        step(0, 0, 0);
        checks++;
        if (if_pc !== 32'h44 || if_insn !== 32'h1000_0011) begin
            errors++;
            $display("FAIL flush_next: pc=%h insn=%h, required 44 10000011", if_pc, if_insn);
        end
    endtask

    task automatic test_flush_stall();
        step(1, 1, 32'h23);
        checks++;
        if (if_en !== 1'b0 || if_insn !== NOP) begin
            errors++;
            $display("FAIL flush_stall_bubble: en=%b insn=%h, required 0 %h", if_en, if_insn, NOP);
        end
        step(0, 0, 0);
        step(0, 0, 0);
        checks++;
        if (if_en !== 1'b1 || if_pc !== 32'h20 || if_insn !== 32'h1000_0008) begin
            errors++;
            $display("FAIL flush_stall_target: en=%b pc=%h insn=%h, required 1 20 10000008", if_en, if_pc, if_insn);
        end
    endtask

    task automatic test_reset_pulse();
        step(1, 0, 0);
        rst_ = 1'b0;
        model_reset();
        #1;
        checks++;
        if (if_en !== 1'b0 || if_insn !== NOP || if_pc !== 32'h0 || if_spm_as_ !== 1'b1) begin
            errors++;
            $display("FAIL reset_pulse: en=%b insn=%h pc=%h as_=%b, required 0 %h 0 1", if_en, if_insn, if_pc, if_spm_as_, NOP);
        end
        @(negedge clk); #1 rst_ = 1'b1;
        step(0, 0, 0);
        checks++;
        if (if_en !== 1'b0) begin
            errors++;
            $display("FAIL reset_pulse_latency: en=%b, required 0", if_en);
        end
        for (int i = 0; i < 2; i++) begin
            step(0, 0, 0);
            checks++;
            if (if_en !== 1'b1 || if_pc !== 32'(4 * i) || if_insn !== 32'h1000_0000 + 32'(i)) begin
                errors++;
                $display("FAIL reset_pulse_restart[%0d]: en=%b pc=%h insn=%h, required 1 %h %h", i, if_en, if_pc, if_insn, 4 * i, 32'h1000_0000 + 32'(i));
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            logic s, f;
            logic [31:0] np;
            s = ($urandom_range(0, 3) == 0);
            f = ($urandom_range(0, 9) == 0);
            np = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : $urandom;
            step(s, f, np);
            checks++;
            if (if_en !== m_en || if_pc !== m_if_pc || if_insn !== m_insn) begin
                errors++;
                $display("FAIL random[%0d]: en=%b pc=%h insn=%h, required %b %h %h", i, if_en, if_pc, if_insn, m_en, m_if_pc, m_insn);
            end
        end
        step(0, 0, 0);
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) mem[i] = 32'h1000_0000 + 32'(i);
        model_reset();
        test_reset();
        test_sequence();
        test_stall();
        test_flush();
        test_flush_stall();
        test_reset_pulse();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
